btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner.
// Synchronises a raw, bouncing button level and debounces it. It produces a
// clean level, one-cycle press and release strobes, a hold flag, and
// auto-repeat strobes while the button is held.
// Every output is a register. Each output is updated on the same edge as the
// state transition that causes it, so it is valid in the first cycle of the
// new state.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold,
  output logic repeat_pulse
);

  // Each counter only ever counts up to parameter-1, so $clog2 bits suffice.
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
  localparam int REP_W  = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    HELD       = 3'd3,
    DB_RELEASE = 3'd4
  } state_t;

  state_t            state_q;
  logic [1:0]        sync_q;
  logic              btn_s;
  logic [DB_W-1:0]   db_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [REP_W-1:0]  rep_cnt_q;
  logic              was_held_q;

  // The second synchronizer flop is the only internal view of the raw input.
  assign btn_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_in};
    end
  end

  // Controller FSM. The counters and registered outputs update on the same
  // edge as the state transition that causes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      rep_cnt_q     <= '0;
      was_held_q    <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold          <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      // Strobes default low, so each one lasts a single cycle.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q  <= DB_PRESS;
            db_cnt_q <= '0;
          end
        end

        DB_PRESS: begin
          if (!btn_s) begin
            // Bounce rejected: go back quietly.
            state_q  <= IDLE;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q     <= PRESSED;
            hold_cnt_q  <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end

        PRESSED: begin
          if (!btn_s) begin
            state_q    <= DB_RELEASE;
            db_cnt_q   <= '0;
            was_held_q <= 1'b0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q      <= HELD;
            rep_cnt_q    <= '0;
            hold         <= 1'b1;
            repeat_pulse <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end

        HELD: begin
          if (!btn_s) begin
            state_q    <= DB_RELEASE;
            db_cnt_q   <= '0;
            was_held_q <= 1'b1;
          end else if (rep_cnt_q == REP_LAST) begin
            // Wrap: the next repeat strobe lands in the following cycle.
            rep_cnt_q    <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
          end
        end

        DB_RELEASE: begin
          if (btn_s) begin
            // A release glitch resumes the previous state without strobes.
            // The level and hold outputs are already correct for it.
            if (was_held_q) begin
              state_q   <= HELD;
              rep_cnt_q <= '0;
            end else begin
              state_q    <= PRESSED;
              hold_cnt_q <= '0;
            end
          end else if (db_cnt_q == DB_LAST) begin
            state_q       <= IDLE;
            btn_level     <= 1'b0;
            hold          <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q   <= IDLE;
          btn_level <= 1'b0;
          hold      <= 1'b0;
        end
      endcase
    end
  end

endmodule
